// File: rtl/chanel_sw_nch_pkg.sv
// Shared types and helpers for the N-channel switch: output-stage state encoding,
// default geometry and the index-width function.
package chanel_sw_nch_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int DEF_W = 8;
    localparam int DEF_N = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chanel_sw_nch_if.sv
// Valid/ready bundle between the channel sources, the switch and the downstream sink.
interface chanel_sw_nch_if
    import chanel_sw_nch_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
);
    localparam int CW = clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_chan;
    logic           out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

endinterface

// File: rtl/chsw_arb.sv
// Channel arbiter: one-hot grant plus index. Round-robin from ptr_i when CHSW_RR_EN
// is defined, otherwise fixed priority with the lowest index winning.
module chsw_arb #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [CW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [CW-1:0] idx_o
);

    logic found;

`ifdef CHSW_RR_EN
    int c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr_i) + k) % N;
            if (!found && req_i[c[CW-1:0]]) begin
                found              = 1'b1;
                gnt_o[c[CW-1:0]]   = 1'b1;
                idx_o              = c[CW-1:0];
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = CW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/chanel_sw_nch.sv
// N-channel valid/ready switch onto one registered output. Define CHSW_RR_EN for
// round-robin arbitration; the default build uses fixed lowest-index priority.
module chanel_sw_nch
    import chanel_sw_nch_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl,
    input  logic [N-1:0]      ch_mask,
    chanel_sw_nch_if.slave    bus
);

    localparam int CW = clog2(N);

    state_e         state_q, state_d;
    logic [W-1:0]   data_q, data_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic [CW-1:0]  arb_ptr;
    logic [N-1:0]   req, gnt;
    logic [CW-1:0]  gnt_idx;
    logic [W-1:0]   sel_data;
    logic           can_load, load, pop;

    assign req      = bus.in_valid & ch_mask;
    assign can_load = ctrl & ((state_q == ST_EMPTY) | bus.out_ready);
    assign load     = can_load & (|req) & ~rst;
    assign pop      = (state_q == ST_FULL) & bus.out_ready;

    chsw_arb #(.N(N), .CW(CW)) u_arb (
        .req_i (req),
        .ptr_i (arb_ptr),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign bus.in_ready = load ? gnt : '0;

`ifdef CHSW_RR_EN
    logic [CW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) ptr_d = (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign arb_ptr = ptr_q;
`else
    assign arb_ptr = '0;
`endif

    // One-hot AND-OR mux of the granted channel's data
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) sel_data = sel_data | bus.in_data[i*W +: W];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        if (load) begin
            state_d = ST_FULL;
            data_d  = sel_data;
            chan_d  = gnt_idx;
        end else if (pop) begin
            state_d = ST_EMPTY;
            data_d  = '0;
            chan_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;

endmodule

// File: tb/tb_chanel_sw_nch.sv
// Bench for chanel_sw_nch: directed scenarios plus randomized traffic against a
// transaction-level model of the switch.
module tb_chanel_sw_nch;
    import chanel_sw_nch_pkg::*;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         ctrl;
    logic [N-1:0] ch_mask;

    chanel_sw_nch_if #(.W(W), .N(N)) bus();

    chanel_sw_nch #(.W(W), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (ctrl),
        .ch_mask (ch_mask),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: what the output register must hold, and the RR start point
    bit         m_live  = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] m_data  = '0;
    int         m_chan  = 0;
    int         m_ptr   = 0;

    function automatic int m_grant();
        logic [N-1:0] r;
        if (rst !== 1'b0) return -1;
        if (!ctrl) return -1;
        if (m_valid && !bus.out_ready) return -1;
        r = bus.in_valid & ch_mask;
        if (r == '0) return -1;
`ifdef CHSW_RR_EN
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (r[k]) return k;
        end
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        g = m_grant();
        if (rst === 1'b1) begin
            m_live  <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= 0;
            m_ptr   <= 0;
        end else if (m_live) begin
            if (g >= 0) begin
                m_valid <= 1'b1;
                m_data  <= bus.in_data[g*W +: W];
                m_chan  <= g;
                m_ptr   <= (g + 1) % N;
            end else if (m_valid && bus.out_ready) begin
                m_valid <= 1'b0;
                m_data  <= '0;
                m_chan  <= 0;
            end
        end
    end

    int           cg;
    logic [N-1:0] cer;

    always @(negedge clk) begin
        #2;
        if (m_live) begin
            cg  = m_grant();
            cer = (cg >= 0) ? (N'(1) << cg) : '0;
            chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("mdl_out_data",  32'(bus.out_data),  32'(m_data));
            chk("mdl_out_chan",  32'(bus.out_chan),  32'(m_chan));
            chk("mdl_in_ready",  32'(bus.in_ready),  32'(cer));
        end
    end

    task automatic drive(input logic r, input logic c, input logic [N-1:0] m,
                         input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        rst           = r;
        ctrl          = c;
        ch_mask       = m;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    initial begin
        // 1: reset with random inputs
        drive(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'($urandom));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 1'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'($urandom));
            #3;
            chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_out_data",  32'(bus.out_data),  32'h00);
            chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
        end

        // 2: single channel transfer
        @(negedge clk);
        drive(1'b0, 1'b1, 4'hF, 4'b0100, 32'h00A5_0000, 1'b1);
        #3;
        chk("t2_in_ready", 32'(bus.in_ready), 32'b0100);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'hF, 4'b0000, 32'h0, 1'b1);
        #3;
        chk("t2_out_valid", 32'(bus.out_valid), 32'h1);
        chk("t2_out_data",  32'(bus.out_data),  32'hA5);
        chk("t2_out_chan",  32'(bus.out_chan),  32'h2);

        // 3: all channels requesting continuously
        @(negedge clk);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'hF, 4'hF, 32'h4433_2211, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #3;
`ifdef CHSW_RR_EN
            chk("t3_out_chan", 32'(bus.out_chan), 32'(k % 4));
            chk("t3_out_data", 32'(bus.out_data), 32'(8'h11 * ((k % 4) + 1)));
`else
            chk("t3_out_chan", 32'(bus.out_chan), 32'h0);
            chk("t3_out_data", 32'(bus.out_data), 32'h11);
`endif
        end

        // 4: stall then back-to-back reload
        @(negedge clk);
        drive(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'hF, 4'b0001, 32'h0000_003C, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 4'hF, 4'b0010, 32'h0000_5A00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            chk("t4_stall_valid", 32'(bus.out_valid), 32'h1);
            chk("t4_stall_data",  32'(bus.out_data),  32'h3C);
            chk("t4_stall_ready", 32'(bus.in_ready),  32'h0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #3;
        chk("t4_reload_ready", 32'(bus.in_ready), 32'b0010);
        @(negedge clk);
        // 5: ctrl dropped while FULL: drain only
        drive(1'b0, 1'b0, 4'hF, 4'hF, 32'h1122_3344, 1'b1);
        #3;
        chk("t4_nobubble_valid", 32'(bus.out_valid), 32'h1);
        chk("t4_nobubble_data",  32'(bus.out_data),  32'h5A);
        chk("t4_nobubble_chan",  32'(bus.out_chan),  32'h1);
        chk("t5_ctrl0_ready",    32'(bus.in_ready),  32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #3;
            chk("t5_drained_valid", 32'(bus.out_valid), 32'h0);
            chk("t5_drained_data",  32'(bus.out_data),  32'h00);
            chk("t5_no_grant",      32'(bus.in_ready),  32'h0);
        end

        // 6: masked channel never granted; reset while FULL
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b1101, 4'b0010, 32'h0000_7700, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("t6_masked_ready", 32'(bus.in_ready),  32'h0);
            chk("t6_masked_valid", 32'(bus.out_valid), 32'h0);
            @(negedge clk);
        end
        drive(1'b0, 1'b1, 4'b1101, 4'b0001, 32'h0000_0099, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'b1101, 4'b0000, 32'h0, 1'b0);
        #3;
        chk("t6_full_data", 32'(bus.out_data), 32'h99);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        #3;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("t6_rst_data",  32'(bus.out_data),  32'h00);

        // Randomized traffic, checked against the model every cycle
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            drive(($urandom % 60) == 0, ($urandom % 8) != 0, 4'($urandom),
                  4'($urandom), $urandom, ($urandom % 4) != 0);
        end

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
